// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_t;

  localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         WORD_CNT_W     = 17;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int size       = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [size-1:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_word_packer.sv
// Packs little-endian bytes into instruction words; first byte lands in bits [7:0].
module boot_word_packer
  import boot_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            word_valid,
  output logic [size-1:0] word
);

  logic [size-9:0] shreg;
  logic [1:0]      byte_cnt;

  // The last byte bypasses the shift register so the word is ready on its handshake.
  assign word_valid = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shreg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= 2'd0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= 2'd0;
    end else if (byte_valid) begin
      shreg    <= {byte_data, shreg[size-9:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a checksummed program frame, writes it to instruction memory and
// releases the core from reset once the checksum matches.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int size       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reload,
  imem_boot_loader_if.master bus,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_error
);

  // state | meaning
  // IDLE  | hunting for magic byte
  // LEN0  | expecting word count low byte
  // LEN1  | expecting word count high byte
  // DATA  | packing and writing words
  // CHK   | expecting checksum byte
  // RUN   | image loaded, core released
  // ERR   | frame failed, hunting for magic

  localparam logic [WORD_CNT_W-1:0] DEPTH = WORD_CNT_W'(1) << ADDR_WIDTH;

  boot_state_t           state;
  logic [15:0]           len;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [7:0]            xor_acc;

  logic            hs;
  logic            frame_start;
  logic            pk_clear;
  logic            pk_valid;
  logic            word_valid;
  logic [size-1:0] word;
  logic [15:0]     len_full;
  logic            oversize;
  logic            last_word;

  assign bus.rx_ready = (state != ST_RUN);
  assign hs           = bus.rx_valid && bus.rx_ready;

  assign frame_start = hs && !reload && (bus.rx_data == BOOT_MAGIC)
                       && ((state == ST_IDLE) || (state == ST_ERR));
  assign pk_clear    = reload || frame_start;
  assign pk_valid    = hs && !reload && (state == ST_DATA);

  assign len_full  = {bus.rx_data, len[7:0]};
  assign oversize  = {1'b0, len_full} > DEPTH;
  assign last_word = (word_cnt + WORD_CNT_W'(1)) == {1'b0, len};

  boot_word_packer #(.size(size)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      len            <= '0;
      word_cnt       <= '0;
      xor_acc        <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_reset     <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (reload) begin
        state      <= ST_IDLE;
        len        <= '0;
        word_cnt   <= '0;
        xor_acc    <= '0;
        core_reset <= 1'b0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
      end else if (hs) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == BOOT_MAGIC) begin
              state    <= ST_LEN0;
              word_cnt <= '0;
              xor_acc  <= '0;
            end
          end
          ST_LEN0: begin
            len[7:0] <= bus.rx_data;
            xor_acc  <= xor_acc ^ bus.rx_data;
            state    <= ST_LEN1;
          end
          ST_LEN1: begin
            len[15:8] <= bus.rx_data;
            xor_acc   <= xor_acc ^ bus.rx_data;
            if (oversize) begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            xor_acc <= xor_acc ^ bus.rx_data;
            if (word_valid) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              bus.imem_wdata <= word;
              word_cnt       <= word_cnt + WORD_CNT_W'(1);
              if (last_word) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (bus.rx_data == xor_acc) begin
              state      <= ST_RUN;
              core_reset <= 1'b1;
              load_done  <= 1'b1;
            end else begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end
          end
          ST_ERR: begin
            // Earlier writes stay in memory; a new frame simply overwrites them.
            if (bus.rx_data == BOOT_MAGIC) begin
              state      <= ST_LEN0;
              load_error <= 1'b0;
              word_cnt   <= '0;
              xor_acc    <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scoreboarded memory writes plus
// status/handshake checks around frame boundaries and reload.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload;
  logic       sel2;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       core_reset, load_done, load_error;
  logic       core_reset2, load_done2, load_error2;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.size(32), .ADDR_WIDTH(10)) bif ();
  imem_boot_loader_if #(.size(32), .ADDR_WIDTH(2))  bif2 ();

  assign bif.rx_data   = rx_data;
  assign bif.rx_valid  = rx_valid & ~sel2;
  assign bif2.rx_data  = rx_data;
  assign bif2.rx_valid = rx_valid & sel2;

  imem_boot_loader #(.size(32), .ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .bus        (bif),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  imem_boot_loader #(.size(32), .ADDR_WIDTH(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .bus        (bif2),
    .core_reset (core_reset2),
    .load_done  (load_done2),
    .load_error (load_error2)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  frame_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          wr_cnt2  = 0;
  int          w0;
  logic [31:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input logic [9:0] addr, input logic [31:0] data);
    wr_t e;
    check("write_expected", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("wr_addr", 64'(addr), 64'(e.addr));
      check("wr_data", 64'(data), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) begin
      wr_cnt++;
      last_data = bif.imem_wdata;
      check_write(bif.imem_addr, bif.imem_wdata);
    end
    if (bif2.imem_we === 1'b1) begin
      wr_cnt2++;
      check_write({8'b0, bif2.imem_addr}, bif2.imem_wdata);
    end
  end

  task automatic drive(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  // Sends frame_q from its magic byte; expected writes are pushed as each word completes.
  task automatic send_frame(input bit hold_last);
    int          len = 0;
    int          di  = 0;
    int          wi  = 0;
    int          n;
    logic [7:0]  b;
    logic [31:0] w = '0;
    n = hold_last ? frame_q.size() - 1 : frame_q.size();
    for (int i = 0; i < n; i++) begin
      b = frame_q[i];
      if (i == 1) len = int'(b);
      if (i == 2) len = len + 256 * int'(b);
      if (i >= 3 && di < len * 4) begin
        w = {b, w[31:8]};
        di++;
        if (di % 4 == 0) begin
          sb.push_back('{addr: 10'(wi), data: w});
          wi++;
        end
      end
      drive(b);
    end
    if (!hold_last) rx_valid = 1'b0;
  endtask

  task automatic load_good(input logic [7:0] chk);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'h10, 8'h00};
    frame_q.push_back(chk);
  endtask

  initial begin
    reset    = 1'b0;
    reload   = 1'b0;
    sel2     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready",   64'(bif.rx_ready),   64'd1);
    check("rst_imem_we",    64'(bif.imem_we),    64'd0);
    check("rst_imem_addr",  64'(bif.imem_addr),  64'd0);
    check("rst_imem_wdata", 64'(bif.imem_wdata), 64'd0);
    check("rst_core_reset", 64'(core_reset),     64'd0);
    check("rst_load_done",  64'(load_done),      64'd0);
    check("rst_load_error", 64'(load_error),     64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // good frame, checksum byte held back to observe release timing
    w0 = wr_cnt;
    load_good(8'hC3);
    send_frame(1'b1);
    check("good_core_held", 64'(core_reset), 64'd0);
    drive(frame_q[frame_q.size()-1]);
    rx_valid = 1'b0;
    check("good_core_reset", 64'(core_reset),  64'd1);
    check("good_load_done",  64'(load_done),   64'd1);
    check("good_rx_ready",   64'(bif.rx_ready), 64'd0);
    check("good_wr_count",   64'(wr_cnt - w0), 64'd2);
    check("good_last_word",  64'(last_data),   64'h0010_0113);
    check("good_sb_empty",   64'(sb.size()),   64'd0);

    // reload while running
    pulse_reload();
    check("reload_run_core_reset", 64'(core_reset),   64'd0);
    check("reload_run_load_done",  64'(load_done),    64'd0);
    check("reload_run_rx_ready",   64'(bif.rx_ready), 64'd1);

    // bad checksum, then a stray byte in ERR, then recovery
    w0 = wr_cnt;
    load_good(8'hC2);
    send_frame(1'b0);
    check("bad_load_error", 64'(load_error), 64'd1);
    check("bad_core_reset", 64'(core_reset), 64'd0);
    check("bad_load_done",  64'(load_done),  64'd0);
    check("bad_wr_count",   64'(wr_cnt - w0), 64'd2);
    drive(8'h00);
    rx_valid = 1'b0;
    check("err_drop_load_error", 64'(load_error), 64'd1);
    load_good(8'hC3);
    send_frame(1'b0);
    check("recover_load_error", 64'(load_error), 64'd0);
    check("recover_load_done",  64'(load_done),  64'd1);
    check("recover_core_reset", 64'(core_reset), 64'd1);
    check("recover_sb_empty",   64'(sb.size()),  64'd0);

    // junk prefix before a good frame
    pulse_reload();
    w0 = wr_cnt;
    drive(8'h00);
    drive(8'hFF);
    drive(8'h5A);
    load_good(8'hC3);
    send_frame(1'b0);
    check("prefix_wr_count",  64'(wr_cnt - w0), 64'd2);
    check("prefix_load_done", 64'(load_done),   64'd1);
    check("prefix_sb_empty",  64'(sb.size()),   64'd0);

    // reload mid-frame with a byte handshaken in the same cycle
    pulse_reload();
    w0 = wr_cnt;
    drive(8'hA5);
    drive(8'h02);
    drive(8'h00);
    drive(8'h93);
    drive(8'h00);
    rx_data  = 8'h50;
    rx_valid = 1'b1;
    pulse_reload();
    rx_valid = 1'b0;
    check("midreload_no_write", 64'(wr_cnt - w0), 64'd0);
    check("midreload_load_done", 64'(load_done), 64'd0);
    load_good(8'hC3);
    send_frame(1'b0);
    check("midreload_wr_count", 64'(wr_cnt - w0), 64'd2);
    check("midreload_done",     64'(load_done),   64'd1);
    check("midreload_sb_empty", 64'(sb.size()),   64'd0);

    // empty frame
    pulse_reload();
    w0 = wr_cnt;
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    @(posedge clk);
    #1;
    check("empty_wr_count",   64'(wr_cnt - w0), 64'd0);
    check("empty_load_done",  64'(load_done),   64'd1);
    check("empty_core_reset", 64'(core_reset),  64'd1);

    // small memory: oversized length errors out immediately
    sel2 = 1'b1;
    drive(8'hA5);
    drive(8'h05);
    drive(8'h00);
    rx_valid = 1'b0;
    check("oversize_load_error", 64'(load_error2), 64'd1);
    drive(8'h11);
    drive(8'h22);
    drive(8'h33);
    drive(8'h44);
    rx_valid = 1'b0;
    check("oversize_no_write",   64'(wr_cnt2),     64'd0);
    check("oversize_core_held",  64'(core_reset2), 64'd0);
    check("oversize_still_err",  64'(load_error2), 64'd1);

    // small memory: length exactly equal to depth is accepted
    frame_q = '{8'hA5, 8'h04, 8'h00};
    for (int k = 0; k < 16; k++) frame_q.push_back(8'(8'h10 + k));
    frame_q.push_back(8'h04);
    send_frame(1'b1);
    check("fullmem_core_held", 64'(core_reset2), 64'd0);
    drive(frame_q[frame_q.size()-1]);
    rx_valid = 1'b0;
    check("fullmem_load_done",  64'(load_done2),  64'd1);
    check("fullmem_load_error", 64'(load_error2), 64'd0);
    check("fullmem_wr_count",   64'(wr_cnt2),     64'd4);
    check("fullmem_sb_empty",   64'(sb.size()),   64'd0);
    check("dut1_unaffected",    64'(load_done),   64'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
